aes_spi_host: RTL
=================

Name: aes_spi_host

Overview:
- SPI master front end that drives one AES encryption transaction into the SPI-attached encrypt stage, which sits directly downstream of it.
- Accepts plaintext, key and key-length from a parallel request port.
- Serialises the 49-byte request frame, waits for the cipher to settle, then clocks out 16 dummy bytes to capture the 128-bit ciphertext.
- Returns the ciphertext on a parallel result port with a done pulse.

Parameters:
- CLK_DIV, 4: sclk half-period in clk cycles; legal values are 2 or more.
- WAIT_CYCLES, 64: clk cycles of idle sclk, with cs held low, between the request frame and the first readback byte.
- CS_GUARD, 4: clk cycles between a cs edge and the first or last sclk edge.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request strobe; sampled only in IDLE.
- plaintext  in  128  data block, MSB = first byte on the wire.
- key  in  256  key, left-aligned: AES-128 uses [255:128], AES-192 uses [255:64]; unused low bits are sent as-is.
- key_len  in  8  key length in bytes: 16, 24 or 32.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when ciphertext is valid or an error is flagged.
- err  out  1  set with done when key_len is illegal; cleared on the next accepted start.
- ciphertext  out  128  result, held until the next accepted start.
- sclk  out  1  SPI clock, mode 0 (idle low).
- cs  out  1  active-low chip select.
- mosi  out  1  SPI data to the slave.
- miso  in  1  SPI data from the slave.

Behaviour:
- Reset, asynchronous while reset=0:
  - State IDLE.
  - cs=1, sclk=0, mosi=0.
  - busy=0, done=0, err=0, ciphertext=0.
  - All counters 0.
- SPI format:
  - Mode 0, MSB first.
  - mosi changes on the sclk falling edge, or during CS_SETUP for the first bit.
  - miso is sampled on the sclk rising edge.
  - One byte takes 16*CLK_DIV clk cycles. Bytes are back-to-back, with no gap inside a phase.
- Frame, 49 bytes:
  - Bytes 0-15: plaintext[127:0], MSB first.
  - Byte 16: key_len.
  - Bytes 17-48: key[255:0].
  - All 32 key bytes are sent regardless of key_len.
- Readback: 16 bytes. mosi is held at 0. Received bytes shift into ciphertext from the LSB end, so the first byte ends up at [127:120].
- State machine:
  - IDLE:
    - start with key_len in {16,24,32}: latch the inputs, set busy=1, clear err, go to CS_SETUP.
    - start with any other key_len: done=1 and err=1 on the next cycle, stay in IDLE, no SPI activity.
  - CS_SETUP: cs=0, present bit 7 of byte 0 on mosi, wait CS_GUARD cycles, go to TX.
  - TX: shift bytes 0-48. After the final falling-edge point of byte 48, go to GAP.
  - GAP: cs stays 0, sclk=0, count WAIT_CYCLES, go to RX.
  - RX: shift 16 bytes. After the 16th byte's last rising-edge sample and the trailing half-period, go to CS_HOLD.
  - CS_HOLD: wait CS_GUARD cycles with sclk=0, then cs=1, go to FINISH.
  - FINISH: update ciphertext from the RX shift register, pulse done for one cycle, set busy=0, go to IDLE.
- Latency, start to done: 2*CS_GUARD + 65*16*CLK_DIV + WAIT_CYCLES + a fixed overhead of at most 4 cycles. The bench measures the overhead once and checks it is constant.
- Boundary conditions:
  - start while busy: ignored, no queueing.
  - Input changes after start: no effect, because inputs are latched.
  - Reset mid-transaction: asynchronous return to reset values. cs deasserts immediately and the partial frame is abandoned. The slave resynchronises on the next cs fall.
  - ciphertext changes only in FINISH; it never shows partial data.
- Counters:
  - Bit counter: 3 bits, wraps 7→0 and advances the byte counter.
  - Byte counter: 7 bits, 0-64 across TX and RX.
  - Divider: ceil(log2(CLK_DIV)) bits.

Decomposition:
- Package aes_spi_pkg holds:
  - REQ_BYTES=49, RSP_BYTES=16.
  - KEY_LEN_128=8'd16, KEY_LEN_192=8'd24, KEY_LEN_256=8'd32.
  - State enum.
- Sub-module spi_byte_master owns the sclk divider and the full-duplex 8-bit shift:
  - Inputs: load, tx_byte.
  - Outputs: rx_byte, byte_done.
  - It is reused by the future decrypt host.

Test Plan:
- AES-128 (FIPS-197): pt=00112233445566778899aabbccddeeff, key=000102..0f followed by 16 zero bytes, key_len=16, against the encrypt stage → ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a, err=0, exactly one done pulse.
- AES-192: key=000102..17 followed by 8 zero bytes, key_len=24 → ciphertext=dda97ca4864cdfe06eaf70a0ec0d7191.
- AES-256: key=000102..1f, key_len=32 → ciphertext=8ea2b7ca516745bfeafc49904b496089. The bench SPI monitor confirms all of the following:
  - exactly 65 bytes on the wire;
  - byte 16 = 0x20;
  - cs low continuously;
  - sclk idle for WAIT_CYCLES in GAP.
- key_len=8'd20 → done and err=1 one cycle after start; cs, sclk and mosi never toggle; ciphertext unchanged.
- start pulsed again while busy, and key/plaintext changed mid-frame → only one transaction occurs and the frame matches the original latched values.
- reset=0 asserted during byte 30 of TX → cs=1 and busy=0 in the same cycle. A subsequent AES-128 transaction still returns 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI host: frame layout, key lengths, FSM states.
package aes_spi_pkg;

  localparam int unsigned REQ_BYTES = 49;
  localparam int unsigned RSP_BYTES = 16;
  localparam int unsigned BLOCK_W   = 128;
  localparam int unsigned KEY_W     = 256;
  localparam int unsigned FRAME_W   = REQ_BYTES * 8;

  localparam logic [7:0] KEY_LEN_128 = 8'd16;
  localparam logic [7:0] KEY_LEN_192 = 8'd24;
  localparam logic [7:0] KEY_LEN_256 = 8'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_TX,
    ST_GAP,
    ST_RX,
    ST_CS_HOLD,
    ST_FINISH
  } state_e;

  // Request frame in wire order: first field is sent first.
  typedef struct packed {
    logic [BLOCK_W-1:0] plaintext;
    logic [7:0]         key_len;
    logic [KEY_W-1:0]   key;
  } req_frame_t;

  function automatic logic key_len_ok(input logic [7:0] len);
    return (len == KEY_LEN_128) || (len == KEY_LEN_192) || (len == KEY_LEN_256);
  endfunction

endpackage

// File: rtl/aes_spi_host_spi_byte_master.sv
// Mode-0 SPI byte engine: sclk divider plus full-duplex 8-bit shift, MSB first.
module spi_byte_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       byte_done
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

  logic             active;
  logic             phase;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;

  // byte_done is raised one cycle early so a reload lands exactly on the closing falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active    <= 1'b0;
      phase     <= 1'b0;
      div       <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= active && phase && (bit_cnt == 3'd7) && (div == DIV_PRE);
      if (load) begin
        active  <= 1'b1;
        phase   <= 1'b0;
        div     <= '0;
        bit_cnt <= '0;
        tx_sh   <= tx_byte;
        mosi    <= tx_byte[7];
        sclk    <= 1'b0;
      end else if (!active) begin
        mosi <= tx_byte[7];
      end else if (div != DIV_LAST) begin
        div <= div + 1'b1;
      end else begin
        div   <= '0;
        phase <= ~phase;
        if (!phase) begin
          sclk    <= 1'b1;
          rx_byte <= {rx_byte[6:0], miso};
        end else begin
          sclk    <= 1'b0;
          bit_cnt <= bit_cnt + 3'd1;
          tx_sh   <= {tx_sh[6:0], 1'b0};
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
            mosi   <= tx_byte[7];
          end else begin
            mosi <= tx_sh[6];
          end
        end
      end
    end
  end

endmodule

// File: rtl/aes_spi_host.sv
// SPI master that sends one AES request frame to the encrypt stage and reads back the ciphertext.
module aes_spi_host
  import aes_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned WAIT_CYCLES = 64,
  parameter int unsigned CS_GUARD    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [KEY_W-1:0]   key,
  input  logic [7:0]         key_len,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               sclk,
  output logic               cs,
  output logic               mosi,
  input  logic               miso
);

  localparam int unsigned CNT_MAX = (WAIT_CYCLES > CS_GUARD) ? WAIT_CYCLES : CS_GUARD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(CS_GUARD - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [6:0] TX_LAST = 7'(REQ_BYTES);
  localparam logic [6:0] RX_LAST = 7'(REQ_BYTES + RSP_BYTES);

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [6:0]         byte_cnt, byte_cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [BLOCK_W-1:0] rx_data, rx_data_d;
  logic [BLOCK_W-1:0] ciphertext_d;
  logic               cs_d, busy_d, done_d, err_d;
  logic               load_c;
  logic [7:0]         rx_byte;
  logic               byte_done;
  req_frame_t         req_c;

  always_comb begin
    req_c.plaintext = plaintext;
    req_c.key_len   = key_len;
    req_c.key       = key;
  end

  spi_byte_master #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk       (clk),
    .reset     (reset),
    .load      (load_c),
    .tx_byte   (frame_q[FRAME_W-1 -: 8]),
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .rx_byte   (rx_byte),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      byte_cnt   <= '0;
      frame_q    <= '0;
      rx_data    <= '0;
      cs         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ciphertext <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      byte_cnt   <= byte_cnt_d;
      frame_q    <= frame_d;
      rx_data    <= rx_data_d;
      cs         <= cs_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      ciphertext <= ciphertext_d;
    end
  end

  // The frame register shifts one byte per load, so it drains to zero and mosi idles low.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    byte_cnt_d   = byte_cnt;
    frame_d      = frame_q;
    rx_data_d    = rx_data;
    cs_d         = cs;
    busy_d       = busy;
    done_d       = 1'b0;
    err_d        = err;
    ciphertext_d = ciphertext;
    load_c       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (key_len_ok(key_len)) begin
            frame_d    = req_c;
            busy_d     = 1'b1;
            err_d      = 1'b0;
            cs_d       = 1'b0;
            cnt_d      = '0;
            byte_cnt_d = '0;
            state_d    = ST_CS_SETUP;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      ST_CS_SETUP: begin
        if (cnt == GUARD_LAST) begin
          load_c     = 1'b1;
          frame_d    = frame_q << 8;
          byte_cnt_d = 7'd1;
          state_d    = ST_TX;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_TX: begin
        if (byte_done) begin
          if (byte_cnt == TX_LAST) begin
            cnt_d   = '0;
            state_d = ST_GAP;
          end else begin
            load_c     = 1'b1;
            frame_d    = frame_q << 8;
            byte_cnt_d = byte_cnt + 7'd1;
          end
        end
      end
      ST_GAP: begin
        if (cnt == WAIT_LAST) begin
          load_c     = 1'b1;
          byte_cnt_d = byte_cnt + 7'd1;
          state_d    = ST_RX;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_RX: begin
        if (byte_done) begin
          rx_data_d = {rx_data[BLOCK_W-9:0], rx_byte};
          if (byte_cnt == RX_LAST) begin
            cnt_d   = '0;
            state_d = ST_CS_HOLD;
          end else begin
            load_c     = 1'b1;
            byte_cnt_d = byte_cnt + 7'd1;
          end
        end
      end
      ST_CS_HOLD: begin
        if (cnt == GUARD_LAST) begin
          cs_d    = 1'b1;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_FINISH: begin
        ciphertext_d = rx_data;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        cnt_d        = '0;
        byte_cnt_d   = '0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
